// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: operation encodings.
package pc_pkg;

  typedef enum logic [2:0] {
    OP_INC    = 3'd0,
    OP_BRANCH = 3'd1,
    OP_JUMP   = 3'd2,
    OP_CALL   = 3'd3,
    OP_RET    = 3'd4
  } op_e;

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO: depth register defines which entries are valid; entry
// storage is not reset.
module pc_ret_stack #(
  parameter int ADDR_W      = 6,
  parameter int STACK_DEPTH = 4,
  parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [ADDR_W-1:0]  push_data,
  output logic [ADDR_W-1:0]  top,
  output logic [DEPTH_W-1:0] depth,
  output logic               full,
  output logic               empty
);

  logic [ADDR_W-1:0]  entries_r [STACK_DEPTH];
  logic [DEPTH_W-1:0] depth_r;
  logic               full_r;
  logic               empty_r;
  logic               do_push_s;
  logic               do_pop_s;
  logic [ADDR_W-1:0]  top_s;

  assign do_push_s = push && !full_r;
  assign do_pop_s  = pop && !empty_r && !do_push_s;

  // Occupancy count with full/empty kept as registers alongside it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      depth_r <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else if (do_push_s) begin
      depth_r <= depth_r + DEPTH_W'(1);
      full_r  <= (depth_r == DEPTH_W'(STACK_DEPTH - 1));
      empty_r <= 1'b0;
    end else if (do_pop_s) begin
      depth_r <= depth_r - DEPTH_W'(1);
      full_r  <= 1'b0;
      empty_r <= (depth_r == DEPTH_W'(1));
    end
  end

  // Entry storage: a push writes the slot just above the current top.
  always_ff @(posedge clock) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (do_push_s && (depth_r == DEPTH_W'(i))) begin
        entries_r[i] <= push_data;
      end
    end
  end

  // Top-of-stack read mux; value is meaningless while empty.
  always_comb begin
    top_s = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      top_s = (depth_r == DEPTH_W'(i + 1)) ? entries_r[i] : top_s;
    end
  end

  assign top   = top_s;
  assign depth = depth_r;
  assign full  = full_r;
  assign empty = empty_r;

endmodule

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: increment, relative branch, jump, call and return
// through a hardware return stack, with sticky overflow/underflow flags.
module pc_seq_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W      = 6,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               stall,
  input  logic [2:0]                         op,
  input  logic                               cond,
  input  logic [ADDR_W-1:0]                  offset,
  input  logic [ADDR_W-1:0]                  target,
  output logic [ADDR_W-1:0]                  pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               stack_full,
  output logic                               stack_empty,
  output logic                               overflow,
  output logic                               underflow
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic [ADDR_W-1:0] pc_r;
  logic              overflow_r;
  logic              underflow_r;
  logic [ADDR_W-1:0] pc_inc_s;
  logic [ADDR_W-1:0] pc_next_s;
  logic [ADDR_W-1:0] top_s;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;
  logic              ovf_set_s;
  logic              unf_set_s;

  assign pc_inc_s = pc_r + ADDR_W'(1);

  // Next-PC and stack-control decode; reserved codes fall through to increment.
  always_comb begin
    pc_next_s = pc_inc_s;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    ovf_set_s = 1'b0;
    unf_set_s = 1'b0;
    case (op)
      OP_INC:    pc_next_s = pc_inc_s;
      OP_BRANCH: pc_next_s = cond ? (pc_r + offset) : pc_inc_s;
      OP_JUMP:   pc_next_s = target;
      OP_CALL: begin
        if (full_s) begin
          pc_next_s = pc_r;
          ovf_set_s = 1'b1;
        end else begin
          pc_next_s = target;
          push_s    = 1'b1;
        end
      end
      OP_RET: begin
        if (empty_s) begin
          pc_next_s = pc_r;
          unf_set_s = 1'b1;
        end else begin
          pc_next_s = top_s;
          pop_s     = 1'b1;
        end
      end
      default:   pc_next_s = pc_inc_s;
    endcase
  end

  // PC and sticky error flags; stall freezes everything.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_r        <= RESET_VEC;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (!stall) begin
      pc_r        <= pc_next_s;
      overflow_r  <= overflow_r | ovf_set_s;
      underflow_r <= underflow_r | unf_set_s;
    end
  end

  pc_ret_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH),
    .DEPTH_W     (DEPTH_W)
  ) u_ret_stack (
    .clock     (clock),
    .reset     (reset),
    .push      (push_s && !stall),
    .pop       (pop_s && !stall),
    .push_data (pc_inc_s),
    .top       (top_s),
    .depth     (depth),
    .full      (full_s),
    .empty     (empty_s)
  );

  assign pc          = pc_r;
  assign stack_full  = full_s;
  assign stack_empty = empty_s;
  assign overflow    = overflow_r;
  assign underflow   = underflow_r;

endmodule
